// File: rtl/gate_state_mac.sv
// gate_state_mac
// Time-multiplexed complex matrix-vector engine: out_state = gate x state for
// an N-qubit register (DIM = 2^N). One complex multiply-accumulate is issued
// per clock. Results are rounded half-up, saturated to W bits, and any
// saturation in the current job raises the sticky overflow flag.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   job (state + gate) presented
//   in_ready   engine idle, job will be accepted
//   state      DIM complex elements; element k = {im, re} at [2Wk +: 2W]
//   gate       DIM*DIM complex elements, (r,c) at k = r*DIM + c
//   out_valid  out_state holds a complete result
//   out_ready  downstream accepts the result
//   out_state  result vector, same packing as state
//   overflow   at least one component of the current result saturated
module gate_state_mac #(
    parameter int N    = 1,
    parameter int W    = 8,
    parameter int FRAC = 6,
    localparam int DIM = 1 << N
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DIM*2*W-1:0]       state,
    input  logic [DIM*DIM*2*W-1:0]   gate,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DIM*2*W-1:0]       out_state,
    output logic                     overflow
);

    localparam int EW    = 2 * W;          // packed width of one complex element
    localparam int ACC_W = 2 * W + N + 1;  // accumulator width, cannot wrap
    localparam int RW    = ACC_W + 1;      // headroom for the rounding add

    localparam logic signed [RW-1:0] HALF    = RW'(2 ** (FRAC - 1));
    localparam logic signed [RW-1:0] SAT_MAX = RW'((2 ** (W - 1)) - 1);
    localparam logic signed [RW-1:0] SAT_MIN = RW'(-(2 ** (W - 1)));

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DONE
    } fsm_e;

    fsm_e                      fsm_q, fsm_d;
    logic [DIM*EW-1:0]         state_q, state_d;
    logic [DIM*DIM*EW-1:0]     gate_q, gate_d;
    logic [N-1:0]              row_q, row_d;
    logic [N-1:0]              col_q, col_d;
    logic signed [ACC_W-1:0]   acc_re_q, acc_re_d;
    logic signed [ACC_W-1:0]   acc_im_q, acc_im_d;
    logic [DIM*EW-1:0]         out_q, out_d;
    logic                      ovf_q, ovf_d;

    logic [2*N-1:0]            k;
    logic signed [W-1:0]       g_re, g_im, s_re, s_im;
    logic signed [ACC_W-1:0]   sum_re, sum_im;
    logic [W:0]                rs_re, rs_im;

    // Round half up, then clamp; MSB of the result flags saturation.
    function automatic logic [W:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [RW-1:0] r;
        r = (RW'(a) + HALF) >>> FRAC;
        if (r > SAT_MAX) begin
            return {1'b1, SAT_MAX[W-1:0]};
        end else if (r < SAT_MIN) begin
            return {1'b1, SAT_MIN[W-1:0]};
        end else begin
            return {1'b0, r[W-1:0]};
        end
    endfunction

    // Operand selection for the current (row, col) step.
    assign k    = {row_q, col_q};
    assign g_re = gate_q[k*EW +: W];
    assign g_im = gate_q[k*EW + W +: W];
    assign s_re = state_q[col_q*EW +: W];
    assign s_im = state_q[col_q*EW + W +: W];

    assign sum_re = acc_re_q + ACC_W'(g_re) * ACC_W'(s_re) - ACC_W'(g_im) * ACC_W'(s_im);
    assign sum_im = acc_im_q + ACC_W'(g_re) * ACC_W'(s_im) + ACC_W'(g_im) * ACC_W'(s_re);

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        gate_d   = gate_q;
        row_d    = row_q;
        col_d    = col_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        out_d    = out_q;
        ovf_d    = ovf_q;
        rs_re    = '0;
        rs_im    = '0;
        in_ready  = (fsm_q == S_IDLE);
        out_valid = (fsm_q == S_DONE);

        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d  = state;
                    gate_d   = gate;
                    row_d    = '0;
                    col_d    = '0;
                    acc_re_d = '0;
                    acc_im_d = '0;
                    ovf_d    = 1'b0;
                    fsm_d    = S_MAC;
                end
            end
            S_MAC: begin
                if (col_q == N'(DIM - 1)) begin
                    // Last column: the row's final sum goes straight to the
                    // output register without passing through the accumulator.
                    rs_re = round_sat(sum_re);
                    rs_im = round_sat(sum_im);
                    out_d[row_q*EW +: W]     = rs_re[W-1:0];
                    out_d[row_q*EW + W +: W] = rs_im[W-1:0];
                    ovf_d    = ovf_q | rs_re[W] | rs_im[W];
                    acc_re_d = '0;
                    acc_im_d = '0;
                    col_d    = '0;
                    if (row_q == N'(DIM - 1)) begin
                        row_d = '0;
                        fsm_d = S_DONE;
                    end else begin
                        row_d = row_q + N'(1);
                    end
                end else begin
                    acc_re_d = sum_re;
                    acc_im_d = sum_im;
                    col_d    = col_q + N'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q    <= S_IDLE;
            state_q  <= '0;
            gate_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            gate_q   <= gate_d;
            row_q    <= row_d;
            col_q    <= col_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_state = out_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_gate_state_mac.sv
// tb_gate_state_mac
// Scoreboard bench for gate_state_mac. Two instances share one clock:
// u1 (N=1) and u2 (N=2), both W=8, FRAC=6. Stimulus pushes the expected
// {overflow, out_state} into a per-instance queue at acceptance; monitors pop
// and compare on each output handshake.
module tb_gate_state_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    // N=1 instance
    logic        rst1 = 1'b1, iv1 = 1'b0, ordy1 = 1'b1;
    logic        ir1, ov1, ovf1;
    logic [31:0] st1 = '0, os1;
    logic [63:0] g1  = '0;

    // N=2 instance
    logic         rst2 = 1'b1, iv2 = 1'b0, ordy2 = 1'b0;
    logic         ir2, ov2, ovf2;
    logic [63:0]  st2 = '0, os2;
    logic [255:0] g2  = '0;

    gate_state_mac #(.N(1), .W(8), .FRAC(6)) u1 (
        .clk(clk), .reset(rst1), .in_valid(iv1), .in_ready(ir1),
        .state(st1), .gate(g1), .out_valid(ov1), .out_ready(ordy1),
        .out_state(os1), .overflow(ovf1)
    );

    gate_state_mac #(.N(2), .W(8), .FRAC(6)) u2 (
        .clk(clk), .reset(rst2), .in_valid(iv2), .in_ready(ir2),
        .state(st2), .gate(g2), .out_valid(ov2), .out_ready(ordy2),
        .out_state(os2), .overflow(ovf2)
    );

    logic [32:0] q1[$];
    logic [64:0] q2[$];

    function automatic logic [15:0] cx(int re, int im);
        logic [7:0] r8, i8;
        r8 = 8'(re);
        i8 = 8'(im);
        return {i8, r8};
    endfunction

    function automatic logic [255:0] diag2(logic [15:0] d);
        logic [255:0] g;
        g = '0;
        for (int i = 0; i < 4; i++) g[(i*4+i)*16 +: 16] = d;
        return g;
    endfunction

    function automatic logic [255:0] fill2(logic [15:0] e);
        logic [255:0] g;
        for (int i = 0; i < 16; i++) g[i*16 +: 16] = e;
        return g;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Monitors: one pop per output handshake.
    always @(negedge clk) begin
        if (!rst1 && ov1 && ordy1) begin
            if (q1.size() == 0) check("mon1_unexpected", 80'(ov1), 80'(0));
            else check("mon1_result", 80'({ovf1, os1}), 80'(q1.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!rst2 && ov2 && ordy2) begin
            if (q2.size() == 0) check("mon2_unexpected", 80'(ov2), 80'(0));
            else check("mon2_result", 80'({ovf2, os2}), 80'(q2.pop_front()));
        end
    end

    task automatic issue1(input logic [63:0] g, input logic [31:0] s,
                          input logic [32:0] e, output int t);
        int b;
        g1 = g; st1 = s; iv1 = 1'b1; b = 0;
        while (!ir1 && b < 100) begin @(posedge clk); #1; b++; end
        check("issue1_ready", 80'(ir1), 80'(1));
        if (ir1) q1.push_back(e);
        @(posedge clk); #1;
        t = cyc;
        iv1 = 1'b0; g1 = ~g; st1 = ~s;   // inputs scrambled after acceptance
    endtask

    task automatic issue2(input logic [255:0] g, input logic [63:0] s,
                          input logic [64:0] e, output int t);
        int b;
        g2 = g; st2 = s; iv2 = 1'b1; b = 0;
        while (!ir2 && b < 100) begin @(posedge clk); #1; b++; end
        check("issue2_ready", 80'(ir2), 80'(1));
        if (ir2) q2.push_back(e);
        @(posedge clk); #1;
        t = cyc;
        iv2 = 1'b0; g2 = ~g; st2 = ~s;
    endtask

    initial begin
        int t, t2, n, b;
        logic [63:0]  gid1, gh1, gy1, gall1;
        logic [63:0]  sid2;

        gid1  = {cx(64,0), cx(0,0), cx(0,0), cx(64,0)};
        gh1   = {cx(-45,0), cx(45,0), cx(45,0), cx(45,0)};
        gy1   = {cx(0,0), cx(0,64), cx(0,-64), cx(0,0)};
        gall1 = {4{cx(64,0)}};
        sid2  = {cx(0,-64), cx(64,0), cx(-3,7), cx(10,-5)};

        // ---------- N=1 ----------
        repeat (3) @(posedge clk);
        #1;
        check("rst1_state", 80'({ir1, ov1, ovf1, os1}), 80'({1'b1, 1'b0, 1'b0, 32'h0}));
        rst1 = 1'b0;
        @(posedge clk); #1;

        issue1(gid1, {cx(0,-32), cx(64,0)}, {1'b0, cx(0,-32), cx(64,0)}, t);
        n = 0;
        while (!ov1 && n < 200) begin @(posedge clk); #1; n++; end
        check("id1_latency", 80'(n + 1), 80'(5));
        @(posedge clk); #1;

        // Back-to-back: second job waits out DONE, accepted DIM^2+2 later.
        issue1(gh1, {cx(0,0), cx(64,0)}, {1'b0, cx(45,0), cx(45,0)}, t);
        issue1(gh1, {cx(64,0), cx(0,0)}, {1'b0, cx(-45,0), cx(45,0)}, t2);
        check("throughput1", 80'(t2 - t), 80'(6));

        issue1(gy1, {cx(0,0), cx(64,0)}, {1'b0, cx(0,64), cx(0,0)}, t);
        issue1(gy1, {cx(0,64), cx(0,0)}, {1'b0, cx(0,0), cx(64,0)}, t);
        issue1(gall1, {cx(127,0), cx(127,0)}, {1'b1, cx(127,0), cx(127,0)}, t);
        issue1(gid1, {cx(0,0), cx(1,0)}, {1'b0, cx(0,0), cx(1,0)}, t);
        issue1(gall1, {cx(-128,0), cx(-128,0)}, {1'b1, cx(-128,0), cx(-128,0)}, t);

        // ---------- N=2 ----------
        check("rst2_state", 80'({ir2, ov2, ovf2, os2}), 80'({1'b1, 1'b0, 1'b0, 64'h0}));
        rst2 = 1'b0;
        @(posedge clk); #1;

        issue2(diag2(cx(64,0)), sid2, {1'b0, sid2}, t);
        n = 0;
        while (!ov2 && n < 200) begin @(posedge clk); #1; n++; end
        check("id2_latency", 80'(n + 1), 80'(17));
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", 80'({ir2, ov2, ovf2, os2}), 80'({1'b0, 1'b1, 1'b0, sid2}));
            @(posedge clk); #1;
        end
        ordy2 = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 80'({ir2, ov2}), 80'(2'b10));

        // Abort a job mid-MAC; its queued expectation is discarded.
        issue2(diag2(cx(64,0)), {4{cx(127,-127)}}, {1'b0, {4{cx(127,-127)}}}, t);
        repeat (6) begin @(posedge clk); #1; end
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        q2.delete();
        check("rst2_mid", 80'({ir2, ov2, ovf2, os2}), 80'({1'b1, 1'b0, 1'b0, 64'h0}));

        issue2(fill2(cx(16,0)), {4{cx(64,0)}}, {1'b0, {4{cx(64,0)}}}, t);
        issue2(fill2(cx(0,16)), {4{cx(64,0)}}, {1'b0, {4{cx(0,64)}}}, t);

        b = 0;
        while ((q1.size() != 0 || q2.size() != 0) && b < 500) begin @(posedge clk); #1; b++; end
        check("drain", 80'(q1.size() + q2.size()), 80'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
